exu_wb_arbiter: RTL

//  Writeback stage directly downstream of the single-cycle ALU and the LSU. Merges ALU results
//  and LSU load data onto the one integer register-file write port. ALU results carry no

---
 rtl/exu_wb_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and LSU load data onto
// the one integer register-file write port. ALU results that lose arbitration
// are queued in a small in-order FIFO. A full FIFO stalls dispatch and takes
// priority over the LSU. The write port is registered.
module exu_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int RFIDXLEN   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_alu_rdwen,
  input  logic [RFIDXLEN-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0]     i_alu_rdwdata,
  output logic                o_alu_stall,
  input  logic                i_lsu_vld,
  input  logic [RFIDXLEN-1:0] i_lsu_rdidx,
  input  logic [XLEN-1:0]     i_lsu_rdata,
  output logic                o_lsu_rdy,
  output logic                o_rf_wen,
  output logic [RFIDXLEN-1:0] o_rf_widx,
  output logic [XLEN-1:0]     o_rf_wdata,
  output logic                o_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [RFIDXLEN-1:0] idx_mem  [FIFO_DEPTH];
  logic [XLEN-1:0]     data_mem [FIFO_DEPTH];

  logic [CW-1:0]       wptr, rptr, count;
  logic                full, empty;
  logic                push, pop, bypass;
  logic                win_vld;
  logic [RFIDXLEN-1:0] win_idx;
  logic [XLEN-1:0]     win_data;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign o_alu_stall = full;
  assign o_lsu_rdy   = !full;

  // Priority pick: full FIFO head, then LSU, then queued ALU, then bypass ALU.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (full) begin
      win_vld  = 1'b1;
      win_idx  = idx_mem[rptr[AW-1:0]];
      win_data = data_mem[rptr[AW-1:0]];
      pop      = 1'b1;
    end else if (i_lsu_vld) begin
      win_vld  = 1'b1;
      win_idx  = i_lsu_rdidx;
      win_data = i_lsu_rdata;
    end else if (!empty) begin
      win_vld  = 1'b1;
      win_idx  = idx_mem[rptr[AW-1:0]];
      win_data = data_mem[rptr[AW-1:0]];
      pop      = 1'b1;
    end else if (i_alu_rdwen) begin
      win_vld  = 1'b1;
      win_idx  = i_alu_rdidx;
      win_data = i_alu_rdwdata;
      bypass   = 1'b1;
    end
    // A push while full is dropped (and flagged) even though the head pops.
    push = i_alu_rdwen && !bypass && !full;
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (push) begin
      idx_mem[wptr[AW-1:0]]  <= i_alu_rdidx;
      data_mem[wptr[AW-1:0]] <= i_alu_rdwdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + CW'(1);
      if (pop)  rptr <= rptr + CW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; x0 winners are consumed but never written.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rf_wen   <= 1'b0;
      o_rf_widx  <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_wen <= win_vld && (win_idx != '0);
      if (win_vld && (win_idx != '0)) begin
        o_rf_widx  <= win_idx;
        o_rf_wdata <= win_data;
      end
    end
  end

  // Sticky protocol error: ALU result presented while dispatch was stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ovf <= 1'b0;
    end else if (i_alu_rdwen && full) begin
      o_ovf <= 1'b1;
    end
  end

endmodule
